control_trace_encoder: RTL and testbench

Inverse of the main control decoder: takes the decoded control bundle the datapath consumes each cycle, re-encodes it into the originating MIPS opcode/function pair, tags it with the PC, and buffers the records in a small FIFO. A debug/trace port drains the FIFO with a valid/ready handshake. The block sits beside the single-cycle datapath, observing the control bus, and never back-pressures the core.

---
 rtl/control_trace_encoder.sv | 142 ++++++++++++++
 tb/tb_control_trace_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/control_trace_encoder.sv
// Re-encodes the decoded control bundle into its MIPS opcode/func pair, tags it with the PC,
// and queues the records for a valid/ready trace consumer. It never stalls the core.
module control_trace_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_en,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [5:0]  in_func,
  input  logic [1:0]  RegDst,
  input  logic [1:0]  Jump,
  input  logic [1:0]  MemtoReg,
  input  logic        ALUSrc,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic [3:0]  ALUOp,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [5:0]  trace_op,
  output logic [5:0]  trace_func,
  output logic [31:0] trace_pc,
  output logic        trace_illegal,
  output logic [15:0] drop_count,
  input  logic        clr_drops
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 45;

  // These fields carry no information the opcode re-encoding needs.
  logic unused_ctrl;
  assign unused_ctrl = ^{MemtoReg, ALUSrc, BranchEQ, BranchNE};

  logic [5:0] enc_op;
  logic [5:0] enc_func;
  logic       enc_ill;

  always_comb begin
    enc_op   = 6'h00;
    enc_func = 6'h00;
    enc_ill  = 1'b0;
    case (Jump)
      2'b10: enc_func = 6'h08;
      2'b01: enc_op = RegWrite ? 6'h03 : 6'h02;
      2'b11: enc_ill = 1'b1;
      default: begin
        case (ALUOp)
          4'b0000: begin
            if (RegDst == 2'b01) enc_func = in_func;
            else                 enc_ill  = 1'b1;
          end
          4'b0001: enc_op = 6'h08;
          4'b0010: enc_op = 6'h0d;
          4'b0011: enc_op = 6'h0f;
          4'b0100: enc_op = 6'h0c;
          4'b0101: enc_op = 6'h04;
          4'b0110: enc_op = 6'h05;
          4'b0111: begin
            enc_op  = 6'h23;
            enc_ill = ~MemRead;
          end
          4'b1000: begin
            enc_op  = 6'h2b;
            enc_ill = ~MemWrite;
          end
          default: enc_ill = 1'b1;
        endcase
      end
    endcase
    if (enc_ill) begin
      enc_op   = 6'h3f;
      enc_func = 6'h00;
    end
  end

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_req, push_acc, pop, full, drop;
  logic [RW-1:0] new_rec;
  logic [RW-1:0] head_next;

  assign new_rec  = {enc_ill, in_pc, enc_func, enc_op};
  assign push_req = trace_en & in_valid;
  assign pop      = trace_valid & trace_ready;
  assign full     = (count_q == CW'(DEPTH));
  assign push_acc = push_req & (~full | pop);
  assign drop     = push_req & ~push_acc;

  always_comb begin
    wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A record being written into the slot that becomes the head is forwarded directly.
    if (push_acc && (wr_ptr_q == rd_ptr_d)) head_next = new_rec;
    else                                    head_next = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= new_rec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      trace_valid   <= 1'b0;
      trace_op      <= '0;
      trace_func    <= '0;
      trace_pc      <= '0;
      trace_illegal <= 1'b0;
      drop_count    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      trace_valid <= (count_d != '0);
      if (count_d != '0) begin
        trace_op      <= head_next[5:0];
        trace_func    <= head_next[11:6];
        trace_pc      <= head_next[43:12];
        trace_illegal <= head_next[44];
      end
      if (clr_drops)                          drop_count <= '0;
      else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_control_trace_encoder.sv
// Directed bench: an encoding vector table followed by FIFO full/drop/reset sequences.
module tb_control_trace_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en, in_valid, trace_ready, clr_drops;
  logic [31:0] in_pc;
  logic [5:0]  in_func;
  logic [1:0]  RegDst, Jump, MemtoReg;
  logic        ALUSrc, RegWrite, MemRead, MemWrite, BranchEQ, BranchNE;
  logic [3:0]  ALUOp;
  logic        trace_valid, trace_illegal;
  logic [5:0]  trace_op, trace_func;
  logic [31:0] trace_pc;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;

  control_trace_encoder #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .in_valid(in_valid), .in_pc(in_pc),
    .in_func(in_func), .RegDst(RegDst), .Jump(Jump), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .BranchEQ(BranchEQ),
    .BranchNE(BranchNE), .ALUOp(ALUOp), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_op(trace_op), .trace_func(trace_func), .trace_pc(trace_pc),
    .trace_illegal(trace_illegal), .drop_count(drop_count), .clr_drops(clr_drops)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  jump;
    logic [3:0]  alu_op;
    logic [1:0]  reg_dst;
    logic        reg_write, mem_read, mem_write;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [5:0]  e_op, e_func;
    logic        e_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [1:0] j, input logic [3:0] a,
                     input logic [1:0] rd, input logic rw, input logic mr, input logic mw,
                     input logic [5:0] f, input logic [31:0] pc, input logic [5:0] eo,
                     input logic [5:0] ef, input logic ei);
    vec_t v;
    v.name = n; v.jump = j; v.alu_op = a; v.reg_dst = rd; v.reg_write = rw;
    v.mem_read = mr; v.mem_write = mw; v.func = f; v.pc = pc;
    v.e_op = eo; v.e_func = ef; v.e_ill = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addi(input logic [31:0] pc);
    Jump = 2'b00; ALUOp = 4'b0001; RegDst = 2'b00; RegWrite = 1'b1; ALUSrc = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; in_func = 6'h00; in_pc = pc; in_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; trace_en = 1'b1; in_valid = 1'b0; trace_ready = 1'b0; clr_drops = 1'b0;
    in_pc = '0; in_func = '0; RegDst = '0; Jump = '0; MemtoReg = '0; ALUSrc = 1'b0;
    RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; BranchEQ = 1'b0; BranchNE = 1'b0;
    ALUOp = '0;

    //   name        jump   aluop    rdst  rw mr mw func   pc            op     func   ill
    add("addi",      2'b00, 4'b0001, 2'b00, 1, 0, 0, 6'h00, 32'h00400000, 6'h08, 6'h00, 0);
    add("jr",        2'b10, 4'b1111, 2'b00, 0, 0, 0, 6'h15, 32'h00400004, 6'h00, 6'h08, 0);
    add("jal",       2'b01, 4'b0000, 2'b10, 1, 0, 0, 6'h00, 32'h00400008, 6'h03, 6'h00, 0);
    add("j",         2'b01, 4'b0000, 2'b00, 0, 0, 0, 6'h00, 32'h0040000c, 6'h02, 6'h00, 0);
    add("rtype_add", 2'b00, 4'b0000, 2'b01, 1, 0, 0, 6'h20, 32'h00400010, 6'h00, 6'h20, 0);
    add("lw",        2'b00, 4'b0111, 2'b00, 1, 1, 0, 6'h00, 32'h00400014, 6'h23, 6'h00, 0);
    add("sw",        2'b00, 4'b1000, 2'b00, 0, 0, 1, 6'h00, 32'h00400018, 6'h2b, 6'h00, 0);
    add("ori",       2'b00, 4'b0010, 2'b00, 1, 0, 0, 6'h11, 32'h0040001c, 6'h0d, 6'h00, 0);
    add("lui",       2'b00, 4'b0011, 2'b00, 1, 0, 0, 6'h00, 32'h00400020, 6'h0f, 6'h00, 0);
    add("andi",      2'b00, 4'b0100, 2'b00, 1, 0, 0, 6'h00, 32'h00400024, 6'h0c, 6'h00, 0);
    add("beq",       2'b00, 4'b0101, 2'b00, 0, 0, 0, 6'h00, 32'h00400028, 6'h04, 6'h00, 0);
    add("bne",       2'b00, 4'b0110, 2'b00, 0, 0, 0, 6'h00, 32'h0040002c, 6'h05, 6'h00, 0);
    add("ill_aluop", 2'b00, 4'b1010, 2'b00, 1, 0, 0, 6'h00, 32'h00400030, 6'h3f, 6'h00, 1);
    add("ill_jump",  2'b11, 4'b0001, 2'b00, 1, 0, 0, 6'h00, 32'h00400034, 6'h3f, 6'h00, 1);
    add("ill_lw",    2'b00, 4'b0111, 2'b00, 1, 0, 0, 6'h00, 32'h00400038, 6'h3f, 6'h00, 1);
    add("ill_sw",    2'b00, 4'b1000, 2'b00, 0, 0, 0, 6'h00, 32'h0040003c, 6'h3f, 6'h00, 1);
    add("ill_rdst",  2'b00, 4'b0000, 2'b00, 1, 0, 0, 6'h20, 32'h00400040, 6'h3f, 6'h00, 1);

    #1;
    chk("reset_valid", 64'(trace_valid), 64'd0);
    chk("reset_drops", 64'(drop_count), 64'd0);
    chk("reset_pc", 64'(trace_pc), 64'd0);
    chk("reset_op", 64'(trace_op), 64'd0);
    step();
    reset = 1'b0;

    // Capture disabled and ready without valid: nothing must appear.
    trace_en = 1'b0; in_valid = 1'b1; trace_ready = 1'b1;
    step();
    chk("en_off_valid", 64'(trace_valid), 64'd0);
    trace_en = 1'b1; in_valid = 1'b0;
    step();
    chk("ready_idle_valid", 64'(trace_valid), 64'd0);

    foreach (vecs[i]) begin
      Jump = vecs[i].jump; ALUOp = vecs[i].alu_op; RegDst = vecs[i].reg_dst;
      RegWrite = vecs[i].reg_write; MemRead = vecs[i].mem_read;
      MemWrite = vecs[i].mem_write; in_func = vecs[i].func; in_pc = vecs[i].pc;
      in_valid = 1'b1; trace_ready = 1'b1;
      step();
      chk($sformatf("%s_valid", vecs[i].name), 64'(trace_valid), 64'd1);
      chk($sformatf("%s_op", vecs[i].name), 64'(trace_op), 64'(vecs[i].e_op));
      chk($sformatf("%s_func", vecs[i].name), 64'(trace_func), 64'(vecs[i].e_func));
      chk($sformatf("%s_pc", vecs[i].name), 64'(trace_pc), 64'(vecs[i].pc));
      chk($sformatf("%s_ill", vecs[i].name), 64'(trace_illegal), 64'(vecs[i].e_ill));
    end
    in_valid = 1'b0;
    step();
    chk("table_drain_valid", 64'(trace_valid), 64'd0);
    chk("table_drops", 64'(drop_count), 64'd0);

    // Fill with ready low: 4 accepted, 2 dropped.
    trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_addi(32'h100 + 32'(4 * i));
      step();
    end
    in_valid = 1'b0;
    chk("full_drops", 64'(drop_count), 64'd2);
    chk("full_valid", 64'(trace_valid), 64'd1);
    chk("full_head", 64'(trace_pc), 64'h100);
    step();
    chk("full_head_stable", 64'(trace_pc), 64'h100);

    // Full with push and pop together: accepted, no drop.
    drive_addi(32'h200); trace_ready = 1'b1;
    step();
    chk("pushpop_drops", 64'(drop_count), 64'd2);
    chk("pushpop_head", 64'(trace_pc), 64'h104);

    // Still full: a drop coincident with clear is not counted.
    drive_addi(32'h204); trace_ready = 1'b0; clr_drops = 1'b1;
    step();
    chk("clr_with_drop", 64'(drop_count), 64'd0);
    clr_drops = 1'b0;
    drive_addi(32'h208);
    step();
    chk("still_full_drop", 64'(drop_count), 64'd1);
    chk("still_full_head", 64'(trace_pc), 64'h104);

    in_valid = 1'b0; trace_ready = 1'b1;
    step();
    chk("drain0", 64'(trace_pc), 64'h108);
    step();
    chk("drain1", 64'(trace_pc), 64'h10c);
    step();
    chk("drain2_tail", 64'(trace_pc), 64'h200);
    chk("drain2_valid", 64'(trace_valid), 64'd1);
    step();
    chk("drain_empty", 64'(trace_valid), 64'd0);
    chk("drain_hold_pc", 64'(trace_pc), 64'h200);

    // Mid-stream asynchronous reset with three queued records.
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_addi(32'h400 + 32'(4 * i));
      step();
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(trace_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(trace_valid), 64'd0);
    chk("async_reset_drops", 64'(drop_count), 64'd0);
    chk("async_reset_pc", 64'(trace_pc), 64'd0);
    #1;
    reset = 1'b0;
    Jump = 2'b01; RegWrite = 1'b1; ALUOp = 4'b0000; in_pc = 32'h500; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_reset_valid", 64'(trace_valid), 64'd1);
    chk("post_reset_pc", 64'(trace_pc), 64'h500);
    chk("post_reset_op", 64'(trace_op), 64'h03);
    trace_ready = 1'b1;
    step();
    chk("post_reset_only_one", 64'(trace_valid), 64'd0);
    chk("post_reset_drops", 64'(drop_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
